arcade_input_mapper: RTL and testbench

Parametrised player-input front end for arcade cores: merges HPS joystick words and PS/2 keyboard events into per-player control vectors, applies SOCD cleaning, converts coin requests into fixed-width, rate-limited pulses, and captures DIP-switch and mod bytes from the HPS download channel. Sits between `hps_io` and the game core in `emu`, replacing hand-written keyboard latches, joystick OR-ing and DIP capture.

---
 rtl/arcade_input_mapper.sv | 198 +++++++++++++++++++
 tb/tb_arcade_input_mapper.sv | 313 +++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/arcade_input_mapper.sv
// Player-input front end: merges HPS joystick words and PS/2 key events into per-player
// controls with SOCD cleaning, stretched coin pulses, and DIP/mod capture from the HPS channel.
module arcade_input_mapper #(
    parameter int unsigned PLAYERS    = 2,
    parameter int unsigned DIP_BYTES  = 8,
    parameter logic [15:0] COIN_PULSE = 16'd4000,
    parameter logic [15:0] COIN_GAP   = 16'd4000,
    parameter int unsigned SOCD       = 1
) (
    input  logic                     clk_sys,
    input  logic                     reset,
    input  logic [10:0]              ps2_key,
    input  logic [16*PLAYERS-1:0]    joy_in,
    input  logic                     ioctl_wr,
    input  logic [7:0]               ioctl_index,
    input  logic [24:0]              ioctl_addr,
    input  logic [7:0]               ioctl_dout,
    output logic [8*PLAYERS-1:0]     p_out,
    output logic [7:0]               merged_out,
    output logic [PLAYERS-1:0]       start_out,
    output logic [PLAYERS-1:0]       coin_out,
    output logic [8*DIP_BYTES-1:0]   dip_out,
    output logic [7:0]               mod_out
);

    typedef enum logic [1:0] {StIdle, StPulse, StGap} coin_state_e;

    // Result is {hit, player[1:0], lane[3:0]}; lanes 0..7 directions/fire, 8 start, 9 coin.
    function automatic logic [6:0] key_map(input logic [7:0] code);
        case (code)
            8'h74: key_map = {1'b1, 2'd0, 4'd0};
            8'h6B: key_map = {1'b1, 2'd0, 4'd1};
            8'h72: key_map = {1'b1, 2'd0, 4'd2};
            8'h75: key_map = {1'b1, 2'd0, 4'd3};
            8'h14: key_map = {1'b1, 2'd0, 4'd4};
            8'h11: key_map = {1'b1, 2'd0, 4'd5};
            8'h29: key_map = {1'b1, 2'd0, 4'd6};
            8'h12: key_map = {1'b1, 2'd0, 4'd7};
            8'h34: key_map = {1'b1, 2'd1, 4'd0};
            8'h23: key_map = {1'b1, 2'd1, 4'd1};
            8'h2B: key_map = {1'b1, 2'd1, 4'd2};
            8'h2D: key_map = {1'b1, 2'd1, 4'd3};
            8'h1C: key_map = {1'b1, 2'd1, 4'd4};
            8'h1B: key_map = {1'b1, 2'd1, 4'd5};
            8'h15: key_map = {1'b1, 2'd1, 4'd6};
            8'h1D: key_map = {1'b1, 2'd1, 4'd7};
            8'h05, 8'h16: key_map = {1'b1, 2'd0, 4'd8};
            8'h06, 8'h1E: key_map = {1'b1, 2'd1, 4'd8};
            8'h26: key_map = {1'b1, 2'd2, 4'd8};
            8'h25: key_map = {1'b1, 2'd3, 4'd8};
            8'h76, 8'h2E: key_map = {1'b1, 2'd0, 4'd9};
            8'h36: key_map = {1'b1, 2'd1, 4'd9};
            8'h3D: key_map = {1'b1, 2'd2, 4'd9};
            8'h3E: key_map = {1'b1, 2'd3, 4'd9};
            default: key_map = 7'd0;
        endcase
    endfunction

    logic                       tog_q;
    logic                       key_ev;
    logic [6:0]                 key_dec;
    logic [PLAYERS-1:0][9:0]    key_q;

    logic [7:0]                 raw;
    logic [PLAYERS-1:0][7:0]    clean;
    logic [7:0]                 merged_d;
    logic [PLAYERS-1:0]         start_d;
    logic [PLAYERS-1:0]         req;
    logic [PLAYERS-1:0]         req_q;

    logic [PLAYERS-1:0][7:0]    p_q;
    logic [7:0]                 merged_q;
    logic [PLAYERS-1:0]         start_q;
    logic [PLAYERS-1:0]         coin_q;

    coin_state_e                state_q [PLAYERS];
    coin_state_e                state_d [PLAYERS];
    logic [15:0]                cnt_q   [PLAYERS];
    logic [15:0]                cnt_d   [PLAYERS];

    // Configuration survives core reset; initialisers give the power-up value.
    logic [DIP_BYTES-1:0][7:0]  dip_q = '0;
    logic [7:0]                 mod_q = '0;

    logic                       unused_bits;

    assign key_dec = key_map(ps2_key[7:0]);
    assign key_ev  = ps2_key[10] != tog_q;

    always_ff @(posedge clk_sys) begin
        tog_q <= ps2_key[10];
        if (reset) begin
            key_q <= '0;
        end else if (key_ev && key_dec[6]) begin
            for (int p = 0; p < PLAYERS; p++) begin
                if (key_dec[5:4] == 2'(p)) key_q[p][key_dec[3:0]] <= ps2_key[9];
            end
        end
    end

    always_comb begin
        raw         = '0;
        clean       = '0;
        merged_d    = '0;
        start_d     = '0;
        req         = '0;
        unused_bits = ps2_key[8];
        for (int p = 0; p < PLAYERS; p++) begin
            raw = key_q[p][7:0] | joy_in[16*p +: 8];
            if (SOCD != 0) begin
                if (raw[0] && raw[1]) raw[1:0] = 2'b00;
                if (raw[2] && raw[3]) raw[3:2] = 2'b00;
            end
            clean[p]    = raw;
            merged_d    = merged_d | raw;
            start_d[p]  = key_q[p][8] | joy_in[16*p+8];
            req[p]      = key_q[p][9] | joy_in[16*p+9];
            unused_bits = unused_bits ^ (^joy_in[16*p+10 +: 6]);
        end
    end

    always_comb begin
        for (int p = 0; p < PLAYERS; p++) begin
            state_d[p] = state_q[p];
            cnt_d[p]   = cnt_q[p];
            case (state_q[p])
                StIdle: begin
                    if (req[p] && !req_q[p]) begin
                        state_d[p] = StPulse;
                        cnt_d[p]   = '0;
                    end
                end
                StPulse: begin
                    if (cnt_q[p] == COIN_PULSE - 16'd1) begin
                        state_d[p] = StGap;
                        cnt_d[p]   = '0;
                    end else begin
                        cnt_d[p] = cnt_q[p] + 16'd1;
                    end
                end
                StGap: begin
                    if (cnt_q[p] == COIN_GAP - 16'd1) begin
                        state_d[p] = StIdle;
                        cnt_d[p]   = '0;
                    end else begin
                        cnt_d[p] = cnt_q[p] + 16'd1;
                    end
                end
                default: begin
                    state_d[p] = StIdle;
                    cnt_d[p]   = '0;
                end
            endcase
        end
    end

    always_ff @(posedge clk_sys) begin
        if (reset) begin
            for (int p = 0; p < PLAYERS; p++) begin
                state_q[p] <= StIdle;
                cnt_q[p]   <= '0;
            end
            // Track the live request so a coin held across reset is not seen as a new edge.
            req_q    <= req;
            p_q      <= '0;
            merged_q <= '0;
            start_q  <= '0;
            coin_q   <= '0;
        end else begin
            for (int p = 0; p < PLAYERS; p++) begin
                state_q[p] <= state_d[p];
                cnt_q[p]   <= cnt_d[p];
                coin_q[p]  <= state_q[p] == StPulse;
            end
            req_q    <= req;
            p_q      <= clean;
            merged_q <= merged_d;
            start_q  <= start_d;
        end
    end

    always_ff @(posedge clk_sys) begin
        if (ioctl_wr && ioctl_index == 8'd254) begin
            for (int n = 0; n < DIP_BYTES; n++) begin
                if (ioctl_addr == 25'(n)) dip_q[n] <= ioctl_dout;
            end
        end
        if (ioctl_wr && ioctl_index == 8'd1) mod_q <= ioctl_dout;
    end

    assign p_out      = p_q;
    assign merged_out = merged_q;
    assign start_out  = start_q;
    assign coin_out   = coin_q;
    assign dip_out    = dip_q;
    assign mod_out    = mod_q;

endmodule

// File: tb/tb_arcade_input_mapper.sv
// Bench for arcade_input_mapper: three parameterisations share stimulus; expected values
// are queued when stimulus is driven and popped when the outputs are sampled.
module tb_arcade_input_mapper;

    logic        clk_sys = 1'b0;
    logic        reset;
    logic [10:0] ps2_key;
    logic [31:0] joy_in;
    logic        ioctl_wr;
    logic [7:0]  ioctl_index;
    logic [24:0] ioctl_addr;
    logic [7:0]  ioctl_dout;

    logic [15:0] p_out,   p_out_n;
    logic [7:0]  merged_out, merged_out_n, merged_out_1, p_out_1, mod_out, mod_out_n, mod_out_1;
    logic [1:0]  start_out, start_out_n, coin_out, coin_out_n;
    logic        start_out_1, coin_out_1;
    logic [63:0] dip_out, dip_out_n, dip_out_1;

    int checks = 0;
    int errors = 0;
    logic [63:0] exp_q[$];
    logic [63:0] e;

    always #5 clk_sys = ~clk_sys;

    arcade_input_mapper #(.PLAYERS(2), .DIP_BYTES(8), .COIN_PULSE(16'd4), .COIN_GAP(16'd3),
                          .SOCD(1)) dut (
        .clk_sys(clk_sys), .reset(reset), .ps2_key(ps2_key), .joy_in(joy_in),
        .ioctl_wr(ioctl_wr), .ioctl_index(ioctl_index), .ioctl_addr(ioctl_addr),
        .ioctl_dout(ioctl_dout), .p_out(p_out), .merged_out(merged_out),
        .start_out(start_out), .coin_out(coin_out), .dip_out(dip_out), .mod_out(mod_out));

    arcade_input_mapper #(.PLAYERS(2), .DIP_BYTES(8), .COIN_PULSE(16'd4), .COIN_GAP(16'd3),
                          .SOCD(0)) dut_n (
        .clk_sys(clk_sys), .reset(reset), .ps2_key(ps2_key), .joy_in(joy_in),
        .ioctl_wr(ioctl_wr), .ioctl_index(ioctl_index), .ioctl_addr(ioctl_addr),
        .ioctl_dout(ioctl_dout), .p_out(p_out_n), .merged_out(merged_out_n),
        .start_out(start_out_n), .coin_out(coin_out_n), .dip_out(dip_out_n),
        .mod_out(mod_out_n));

    arcade_input_mapper #(.PLAYERS(1), .DIP_BYTES(8), .COIN_PULSE(16'd4), .COIN_GAP(16'd3),
                          .SOCD(1)) dut_1 (
        .clk_sys(clk_sys), .reset(reset), .ps2_key(ps2_key), .joy_in(joy_in[15:0]),
        .ioctl_wr(ioctl_wr), .ioctl_index(ioctl_index), .ioctl_addr(ioctl_addr),
        .ioctl_dout(ioctl_dout), .p_out(p_out_1), .merged_out(merged_out_1),
        .start_out(start_out_1), .coin_out(coin_out_1), .dip_out(dip_out_1),
        .mod_out(mod_out_1));

    task automatic tick(input int n);
        repeat (n) @(negedge clk_sys);
    endtask

    task automatic ps2_event(input logic pressed, input logic [7:0] code);
        ps2_key = {~ps2_key[10], pressed, 1'b0, code};
    endtask

    task automatic test_reset;
        reset = 1'b1;
        exp_q.push_back(64'h0);
        exp_q.push_back(64'h0);
        exp_q.push_back(64'h0);
        exp_q.push_back(64'h0);
        tick(3);
        e = exp_q.pop_front(); checks++;
        if (p_out !== e[15:0]) begin errors++; $display("FAIL reset_p_out: got %h want %h", p_out, e[15:0]); end
        e = exp_q.pop_front(); checks++;
        if ({merged_out, start_out, coin_out} !== e[11:0]) begin
            errors++; $display("FAIL reset_misc: got %h want %h", {merged_out, start_out, coin_out}, e[11:0]);
        end
        e = exp_q.pop_front(); checks++;
        if (dip_out !== e) begin errors++; $display("FAIL powerup_dip: got %h want %h", dip_out, e); end
        e = exp_q.pop_front(); checks++;
        if (mod_out !== e[7:0]) begin errors++; $display("FAIL powerup_mod: got %h want %h", mod_out, e[7:0]); end
        reset = 1'b0;
        tick(1);
    endtask

    task automatic test_joy;
        logic [31:0] stim [3] = '{32'h0000_0001, 32'h0010_0001, 32'h0100_0000};
        logic [15:0] exp_p [3] = '{16'h0001, 16'h1001, 16'h0000};
        logic [7:0]  exp_m [3] = '{8'h01, 8'h11, 8'h00};
        logic [1:0]  exp_s [3] = '{2'b00, 2'b00, 2'b10};
        for (int i = 0; i < 3; i++) begin
            joy_in = stim[i];
            exp_q.push_back({38'h0, exp_s[i], exp_m[i], exp_p[i]});
            tick(1);
            e = exp_q.pop_front(); checks++;
            if ({start_out, merged_out, p_out} !== e[25:0]) begin
                errors++;
                $display("FAIL joy_%0d: got %h want %h", i, {start_out, merged_out, p_out}, e[25:0]);
            end
        end
        joy_in = '0;
        tick(1);
    endtask

    task automatic test_socd;
        logic [31:0] stim [3] = '{32'h0000_0003, 32'h0000_000C, 32'h000F_0005};
        logic [15:0] exp_s1 [3] = '{16'h0000, 16'h0000, 16'h0005};
        logic [15:0] exp_s0 [3] = '{16'h0003, 16'h000C, 16'h0F05};
        for (int i = 0; i < 3; i++) begin
            joy_in = stim[i];
            exp_q.push_back({32'h0, exp_s0[i], exp_s1[i]});
            tick(1);
            e = exp_q.pop_front(); checks += 2;
            if (p_out !== e[15:0]) begin
                errors++; $display("FAIL socd1_%0d: got %h want %h", i, p_out, e[15:0]);
            end
            if (p_out_n !== e[31:16]) begin
                errors++; $display("FAIL socd0_%0d: got %h want %h", i, p_out_n, e[31:16]);
            end
        end
        joy_in = '0;
        tick(1);
    endtask

    task automatic test_keys;
        ps2_event(1'b1, 8'h14);
        exp_q.push_back(64'h0000);
        exp_q.push_back(64'h0010);
        tick(1);
        e = exp_q.pop_front(); checks++;
        if (p_out !== e[15:0]) begin errors++; $display("FAIL key_edge1: got %h want %h", p_out, e[15:0]); end
        tick(1);
        e = exp_q.pop_front(); checks++;
        if (p_out !== e[15:0]) begin errors++; $display("FAIL key_press: got %h want %h", p_out, e[15:0]); end

        ps2_event(1'b0, 8'h14);
        exp_q.push_back(64'h0000);
        tick(2);
        e = exp_q.pop_front(); checks++;
        if (p_out !== e[15:0]) begin errors++; $display("FAIL key_release: got %h want %h", p_out, e[15:0]); end

        ps2_event(1'b1, 8'h1C);
        exp_q.push_back(64'h1000);
        exp_q.push_back(64'h00);
        tick(2);
        e = exp_q.pop_front(); checks++;
        if (p_out !== e[15:0]) begin errors++; $display("FAIL key_p2: got %h want %h", p_out, e[15:0]); end
        e = exp_q.pop_front(); checks++;
        if (p_out_1 !== e[7:0]) begin errors++; $display("FAIL key_p2_ignored: got %h want %h", p_out_1, e[7:0]); end

        // Key event and joystick change together, then a second key event on the next clock.
        ps2_event(1'b1, 8'h75);
        joy_in = 32'h0000_0001;
        exp_q.push_back(64'h1001);
        exp_q.push_back(64'h1009);
        tick(1);
        e = exp_q.pop_front(); checks++;
        if (p_out !== e[15:0]) begin errors++; $display("FAIL simul_joy: got %h want %h", p_out, e[15:0]); end
        tick(1);
        e = exp_q.pop_front(); checks++;
        if (p_out !== e[15:0]) begin errors++; $display("FAIL simul_key: got %h want %h", p_out, e[15:0]); end

        joy_in = '0;
        ps2_event(1'b1, 8'h6B);
        tick(1);
        ps2_event(1'b1, 8'h2D);
        exp_q.push_back(64'h180A);
        tick(2);
        e = exp_q.pop_front(); checks++;
        if (p_out !== e[15:0]) begin errors++; $display("FAIL back_to_back: got %h want %h", p_out, e[15:0]); end

        reset = 1'b1;
        tick(2);
        reset = 1'b0;
        exp_q.push_back(64'h0);
        tick(3);
        e = exp_q.pop_front(); checks++;
        if ({merged_out, p_out} !== e[23:0]) begin
            errors++; $display("FAIL key_reset: got %h want %h", {merged_out, p_out}, e[23:0]);
        end
    endtask

    task automatic test_coin;
        bit req_tab  [20] = '{1,1,0,0,0,0,0,1,1,0,0,0,1,1,0,0,0,0,0,0};
        bit coin_tab [20] = '{0,1,1,1,1,0,0,0,0,0,0,0,0,1,1,1,1,0,0,0};
        bit kb_tab   [8]  = '{0,0,1,1,1,1,0,0};
        int highs;
        highs = 0;
        for (int k = 1; k <= 20; k++) begin
            joy_in[9] = 1'b1;
            exp_q.push_back((k >= 2 && k <= 5) ? 64'h1 : 64'h0);
            tick(1);
            e = exp_q.pop_front(); checks++;
            if (coin_out !== e[1:0]) begin
                errors++; $display("FAIL coin_held_%0d: got %b want %b", k, coin_out, e[1:0]);
            end
            highs += int'(coin_out[0]);
        end
        checks++;
        if (highs != 4) begin errors++; $display("FAIL coin_pulse_len: got %0d want 4", highs); end
        joy_in[9] = 1'b0;
        tick(10);
        for (int k = 1; k <= 20; k++) begin
            joy_in[9] = req_tab[k-1];
            exp_q.push_back({63'h0, coin_tab[k-1]});
            tick(1);
            e = exp_q.pop_front(); checks++;
            if (coin_out !== e[1:0]) begin
                errors++; $display("FAIL coin_retrig_%0d: got %b want %b", k, coin_out, e[1:0]);
            end
        end
        tick(5);
        ps2_event(1'b1, 8'h2E);
        for (int k = 1; k <= 8; k++) begin
            exp_q.push_back({63'h0, kb_tab[k-1]});
            tick(1);
            e = exp_q.pop_front(); checks++;
            if (coin_out !== e[1:0]) begin
                errors++; $display("FAIL coin_key_%0d: got %b want %b", k, coin_out, e[1:0]);
            end
        end
        ps2_event(1'b0, 8'h2E);
        tick(10);
    endtask

    task automatic test_dip;
        logic [7:0]  idx [5] = '{8'd254, 8'd254, 8'd254, 8'd1, 8'd254};
        logic [24:0] adr [5] = '{25'd2, 25'd8, 25'd7, 25'd0, 25'd0};
        logic [7:0]  dat [5] = '{8'hA5, 8'hFF, 8'h3C, 8'h01, 8'h77};
        logic        wr  [5] = '{1'b1, 1'b1, 1'b1, 1'b1, 1'b0};
        logic [63:0] exp_d [5] = '{64'h0000_0000_00A5_0000, 64'h0000_0000_00A5_0000,
                                   64'h3C00_0000_00A5_0000, 64'h3C00_0000_00A5_0000,
                                   64'h3C00_0000_00A5_0000};
        logic [7:0]  exp_m [5] = '{8'h00, 8'h00, 8'h00, 8'h01, 8'h01};
        for (int i = 0; i < 5; i++) begin
            ioctl_wr = wr[i]; ioctl_index = idx[i]; ioctl_addr = adr[i]; ioctl_dout = dat[i];
            exp_q.push_back(exp_d[i]);
            exp_q.push_back({56'h0, exp_m[i]});
            tick(1);
            ioctl_wr = 1'b0;
            e = exp_q.pop_front(); checks++;
            if (dip_out !== e) begin errors++; $display("FAIL dip_%0d: got %h want %h", i, dip_out, e); end
            e = exp_q.pop_front(); checks++;
            if (mod_out !== e[7:0]) begin errors++; $display("FAIL mod_%0d: got %h want %h", i, mod_out, e[7:0]); end
        end
        reset = 1'b1;
        exp_q.push_back(64'h3C00_0000_00A5_0000);
        exp_q.push_back(64'h01);
        tick(2);
        reset = 1'b0;
        tick(1);
        e = exp_q.pop_front(); checks++;
        if (dip_out !== e) begin errors++; $display("FAIL dip_after_reset: got %h want %h", dip_out, e); end
        e = exp_q.pop_front(); checks++;
        if (mod_out !== e[7:0]) begin errors++; $display("FAIL mod_after_reset: got %h want %h", mod_out, e[7:0]); end
    endtask

    task automatic test_players1;
        ps2_event(1'b1, 8'h06);
        exp_q.push_back(64'h0);
        exp_q.push_back(64'h2);
        tick(2);
        e = exp_q.pop_front(); checks++;
        if (start_out_1 !== e[0]) begin errors++; $display("FAIL p1_start_ignored: got %b want %b", start_out_1, e[0]); end
        e = exp_q.pop_front(); checks++;
        if (start_out !== e[1:0]) begin errors++; $display("FAIL p2_start: got %b want %b", start_out, e[1:0]); end

        ps2_event(1'b1, 8'h36);
        exp_q.push_back(64'h0);
        exp_q.push_back(64'h2);
        tick(3);
        e = exp_q.pop_front(); checks++;
        if (coin_out_1 !== e[0]) begin errors++; $display("FAIL p1_coin_ignored: got %b want %b", coin_out_1, e[0]); end
        e = exp_q.pop_front(); checks++;
        if (coin_out !== e[1:0]) begin errors++; $display("FAIL p2_coin: got %b want %b", coin_out, e[1:0]); end
        ps2_event(1'b0, 8'h36);
        tick(1);
        ps2_event(1'b0, 8'h06);
        tick(10);

        joy_in[9] = 1'b1;
        exp_q.push_back(64'h1);
        tick(2);
        e = exp_q.pop_front(); checks++;
        if (coin_out !== e[1:0]) begin errors++; $display("FAIL pulse_before_reset: got %b want %b", coin_out, e[1:0]); end
        reset = 1'b1;
        joy_in[9] = 1'b0;
        exp_q.push_back(64'h0);
        tick(1);
        e = exp_q.pop_front(); checks++;
        if ({coin_out_1, coin_out} !== e[2:0]) begin
            errors++; $display("FAIL reset_mid_pulse: got %b want %b", {coin_out_1, coin_out}, e[2:0]);
        end
        reset = 1'b0;
        exp_q.push_back(64'h0);
        tick(3);
        e = exp_q.pop_front(); checks++;
        if (coin_out !== e[1:0]) begin errors++; $display("FAIL coin_after_reset: got %b want %b", coin_out, e[1:0]); end
    endtask

    initial begin
        reset       = 1'b1;
        ps2_key     = '0;
        joy_in      = '0;
        ioctl_wr    = 1'b0;
        ioctl_index = '0;
        ioctl_addr  = '0;
        ioctl_dout  = '0;
        test_reset();
        test_joy();
        test_socd();
        test_keys();
        test_coin();
        test_dip();
        test_players1();
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
